// File: rtl/tdm_demultiplexer_pkg.sv
// Shared defaults and helpers for the TDM receive-side demultiplexer.
// The selector side imports the same lane geometry from here.
package tdm_demultiplexer_pkg;

    localparam int DEF_WIDTH  = 1;
    localparam int DEF_LANES  = 4;
    localparam int DEF_ADDR_W = 2;

    // What an accepted sample does to the frame being assembled.
    typedef enum logic [1:0] {
        EV_NONE     = 2'd0,
        EV_WRITE    = 2'd1,
        EV_COMPLETE = 2'd2,
        EV_RESYNC   = 2'd3
    } sample_ev_e;

    // Lane i of a packed frame lives at [lane_lsb(i, width) +: width].
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/tdm_demultiplexer_if.sv
// Serial-in / frame-out bundle of the TDM demultiplexer.
// master = stream source and frame consumer, slave = the demultiplexer.
interface tdm_demultiplexer_if
    import tdm_demultiplexer_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int LANES  = DEF_LANES,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic [WIDTH-1:0]       in_data;
    logic                   in_valid;
    logic                   in_sof;
    logic                   in_ready;
    logic [LANES*WIDTH-1:0] out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [ADDR_W-1:0]      lane_addr;
    logic                   frame_err;

    modport master (
        output in_data, in_valid, in_sof, out_ready,
        input  in_ready, out_data, out_valid, lane_addr, frame_err
    );

    modport slave (
        input  in_data, in_valid, in_sof, out_ready,
        output in_ready, out_data, out_valid, lane_addr, frame_err
    );

endinterface

// File: rtl/tdm_demultiplexer_lane_address_counter.sv
// Rotating lane address: mod-2^ADDR_W up-counter with load-to-1 on start-of-frame
// and a terminal-count flag at the last lane.
module tdm_demultiplexer_lane_address_counter
    import tdm_demultiplexer_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_one,
    input  logic              inc_en,
    output logic [ADDR_W-1:0] addr,
    output logic              term_cnt
);

    logic [ADDR_W-1:0] addr_d;
    logic [ADDR_W-1:0] addr_q;

    // A sof sample always lands in lane 0, so the next address is 1 regardless of
    // where the counter was; natural binary wrap gives the silent LANES-1 -> 0 rollover.
    always_comb begin
        addr_d = addr_q;
        if (load_one) begin
            addr_d = ADDR_W'(1);
        end else if (inc_en) begin
            addr_d = addr_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr     = addr_q;
    assign term_cnt = &addr_q;

endmodule

// File: rtl/tdm_demultiplexer.sv
// Receive-side TDM demultiplexer: steers serial samples into LANES lanes and
// presents each completed frame as one parallel word with a valid/ready handshake.
module tdm_demultiplexer
    import tdm_demultiplexer_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int LANES  = DEF_LANES,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                clk,
    input  logic                reset,
    tdm_demultiplexer_if.slave  bus
);

    localparam int ASM_W = (LANES - 1) * WIDTH;

    logic                   in_ready;
    logic                   accept;
    logic [ADDR_W-1:0]      lane_addr;
    logic [ADDR_W-1:0]      target;
    logic                   term_cnt;
    sample_ev_e             ev;

    logic [ASM_W-1:0]       asm_d;
    logic [ASM_W-1:0]       asm_q;
    logic [LANES*WIDTH-1:0] out_data_d;
    logic [LANES*WIDTH-1:0] out_data_q;
    logic                   out_valid_d;
    logic                   out_valid_q;
    logic                   frame_err_d;
    logic                   frame_err_q;

    // Only the final lane can stall: lanes 0..LANES-2 land in the assembly bank,
    // which gives one frame of buffering behind a blocked output register.
    assign in_ready = !(term_cnt && out_valid_q && !bus.out_ready);
    assign accept   = bus.in_valid && in_ready;
    assign target   = bus.in_sof ? '0 : lane_addr;

    always_comb begin
        ev = EV_NONE;
        if (accept) begin
            if (bus.in_sof && (lane_addr != '0)) begin
                ev = EV_RESYNC;
            end else if (target == ADDR_W'(LANES - 1)) begin
                ev = EV_COMPLETE;
            end else begin
                ev = EV_WRITE;
            end
        end
    end

    tdm_demultiplexer_lane_address_counter #(
        .ADDR_W (ADDR_W)
    ) u_lane_addr (
        .clk      (clk),
        .reset    (reset),
        .load_one (accept && bus.in_sof),
        .inc_en   (accept && !bus.in_sof),
        .addr     (lane_addr),
        .term_cnt (term_cnt)
    );

    // Resync needs no explicit clear: the new frame rewrites every lane in order
    // before it can complete, so stale lanes are never emitted.
    always_comb begin
        asm_d = asm_q;
        if ((ev == EV_WRITE) || (ev == EV_RESYNC)) begin
            asm_d[lane_lsb(int'(target), WIDTH) +: WIDTH] = bus.in_data;
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
        if (ev == EV_COMPLETE) begin
            out_data_d  = {bus.in_data, asm_q};
            out_valid_d = 1'b1;
        end
        frame_err_d = (ev == EV_RESYNC);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            asm_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            asm_q       <= asm_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.lane_addr = lane_addr;
    assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_tdm_demultiplexer.sv
// Bench for tdm_demultiplexer: directed frames with literal expectations plus a
// randomized run checked every cycle against a frame-level reference model.
module tb_tdm_demultiplexer;

    localparam int WIDTH  = 1;
    localparam int LANES  = 4;
    localparam int ADDR_W = 2;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    tdm_demultiplexer_if #(.WIDTH(WIDTH), .LANES(LANES), .ADDR_W(ADDR_W)) bus ();

    tdm_demultiplexer #(.WIDTH(WIDTH), .LANES(LANES), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_frames = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: frame being assembled as an array of lanes, a one-slot
    // output buffer and a queue of completed frames awaiting consumption.
    int           m_next = 0;
    logic [3:0]   m_part = '0;
    logic         m_vld  = 1'b0;
    logic [3:0]   m_out  = '0;
    logic         m_err  = 1'b0;
    bit           m_live = 1'b0;
    logic [3:0]   exp_q[$];
    bit           prev_hold = 1'b0;
    logic [3:0]   prev_data = '0;

    always @(negedge clk) begin
        bit         m_rdy;
        int         tgt;
        logic [3:0] front;
        m_rdy = !((m_next == LANES - 1) && m_vld && !bus.out_ready);
        if (m_live) begin
            chk("in_ready",  64'(bus.in_ready),  64'(m_rdy));
            chk("out_valid", 64'(bus.out_valid), 64'(m_vld));
            chk("out_data",  64'(bus.out_data),  64'(m_out));
            chk("lane_addr", 64'(bus.lane_addr), 64'(m_next));
            chk("frame_err", 64'(bus.frame_err), 64'(m_err));
            if (prev_hold) chk("hold_stable", 64'(bus.out_data), 64'(prev_data));
            if (!reset && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_duplicate", 64'(1), 64'(0));
                end else begin
                    front = exp_q.pop_front();
                    chk("sb_order", 64'(bus.out_data), 64'(front));
                    n_frames++;
                end
            end
        end
        prev_hold = m_live && !reset && bus.out_valid && !bus.out_ready;
        prev_data = bus.out_data;
        if (reset) begin
            m_next = 0; m_part = '0; m_vld = 1'b0; m_out = '0; m_err = 1'b0;
            exp_q.delete();
            m_live = 1'b1;
        end else if (m_live) begin
            if (m_vld && bus.out_ready) m_vld = 1'b0;
            m_err = 1'b0;
            if (bus.in_valid && m_rdy) begin
                tgt = bus.in_sof ? 0 : m_next;
                if (bus.in_sof && m_next != 0) m_err = 1'b1;
                m_part[tgt] = bus.in_data;
                if (tgt == LANES - 1) begin
                    m_out = m_part;
                    m_vld = 1'b1;
                    exp_q.push_back(m_part);
                end
                m_next = (tgt + 1) % LANES;
            end
        end
    end

    task automatic cyc(input logic v, input logic d, input logic s, input logic r);
        @(posedge clk);
        #1;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_sof    = s;
        bus.out_ready = r;
    endtask

    task automatic look();
        #1;
    endtask

    logic [7:0] b2b;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = 1'b0; bus.in_sof = 1'b0; bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset held two cycles in the middle of a frame
        cyc(1, 1, 1, 1);
        cyc(1, 0, 0, 1);
        @(posedge clk); #1 reset = 1'b1; bus.in_data = 1'b1;
        @(posedge clk); look();
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_out_data",  64'(bus.out_data),  64'(0));
        chk("rst_lane_addr", 64'(bus.lane_addr), 64'(0));
        chk("rst_frame_err", 64'(bus.frame_err), 64'(0));
        chk("rst_in_ready",  64'(bus.in_ready),  64'(1));
        @(posedge clk); #1 reset = 1'b0; bus.in_valid = 1'b0;

        // Single clean frame 1,0,1,1
        cyc(1, 1, 1, 1); cyc(1, 0, 0, 1); cyc(1, 1, 0, 1); cyc(1, 1, 0, 1);
        cyc(0, 0, 0, 1); look();
        chk("f1_valid", 64'(bus.out_valid), 64'(1));
        chk("f1_data",  64'(bus.out_data),  64'(4'b1101));
        chk("f1_noerr", 64'(bus.frame_err), 64'(0));
        cyc(0, 0, 0, 1); look();
        chk("f1_valid_drop", 64'(bus.out_valid), 64'(0));

        // Back-to-back frames 1,0,0,0 / 0,1,1,0
        b2b = 8'b0110_0001;
        for (int i = 0; i < 8; i++) begin
            cyc(1, b2b[i], (i % 4) == 0, 1); look();
            chk("b2b_in_ready", 64'(bus.in_ready), 64'(1));
            if (i == 4) begin
                chk("b2b_f1_valid", 64'(bus.out_valid), 64'(1));
                chk("b2b_f1_data",  64'(bus.out_data),  64'(4'b0001));
            end
        end
        cyc(0, 0, 0, 1); look();
        chk("b2b_f2_valid", 64'(bus.out_valid), 64'(1));
        chk("b2b_f2_data",  64'(bus.out_data),  64'(4'b0110));
        cyc(0, 0, 0, 1);

        // Back-pressure: 1111 pending while the next frame 0,1,0,0 arrives
        cyc(1, 1, 1, 0); cyc(1, 1, 0, 0); cyc(1, 1, 0, 0); cyc(1, 1, 0, 0);
        cyc(1, 0, 1, 0); look();
        chk("bp_f1_data", 64'(bus.out_data), 64'(4'b1111));
        cyc(1, 1, 0, 0); cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0); look();
        chk("bp_stall_ready", 64'(bus.in_ready),  64'(0));
        chk("bp_stall_addr",  64'(bus.lane_addr), 64'(3));
        cyc(1, 0, 0, 0); look();
        chk("bp_still_stall", 64'(bus.in_ready), 64'(0));
        chk("bp_hold_data",   64'(bus.out_data), 64'(4'b1111));
        cyc(1, 0, 0, 1); look();
        chk("bp_release_ready", 64'(bus.in_ready), 64'(1));
        cyc(0, 0, 0, 0); look();
        chk("bp_f2_valid", 64'(bus.out_valid), 64'(1));
        chk("bp_f2_data",  64'(bus.out_data),  64'(4'b0010));
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1); look();
        chk("bp_drained", 64'(bus.out_valid), 64'(0));

        // Resync: 1,1 then sof with 0, then 1,0,1
        cyc(1, 1, 1, 1); cyc(1, 1, 0, 1); cyc(1, 0, 1, 1);
        cyc(1, 1, 0, 1); look();
        chk("rs_err_pulse", 64'(bus.frame_err), 64'(1));
        chk("rs_addr",      64'(bus.lane_addr), 64'(1));
        cyc(1, 0, 0, 1); look();
        chk("rs_err_clear", 64'(bus.frame_err), 64'(0));
        cyc(1, 1, 0, 1);
        cyc(0, 0, 0, 1); look();
        chk("rs_valid", 64'(bus.out_valid), 64'(1));
        chk("rs_data",  64'(bus.out_data),  64'(4'b1010));
        cyc(0, 0, 0, 1);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 10000; i++) begin
            cyc($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 9) == 0,
                $urandom_range(0, 2) != 0);
            reset = ($urandom_range(0, 499) == 0);
        end
        cyc(0, 0, 0, 1); reset = 1'b0;
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1); look();
        chk("rnd_no_lost_frames", 64'(exp_q.size()), 64'(0));
        chk("rnd_frames_seen",    64'(n_frames > 500), 64'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
